// File: rtl/filter_acq_ctrl.sv
// filter_acq_ctrl
//
// Acquisition controller for one averaging-filter instance. An accepted arm
// clears the filter and waits for a trigger. The filter is then enabled
// until the programmed number of window results has been captured, or until
// the filter stays silent for too long. Each result is buffered in a small
// FIFO and streamed out on a valid/ready port.
//
// Ports:
//   clock_in     system clock, rising edge
//   reset        synchronous, active-low
//   arm          start an acquisition (IDLE only)
//   trig         trigger (WAIT_TRIG only)
//   abort        cancel from any non-IDLE state, outranks every other input
//   win_count    windows to collect; 0 acts as 1, values above NWIN act as NWIN
//   filt_en      filter enable (RUN only)
//   filt_clr     filter clear (every state except RUN)
//   filt_data    filter window result
//   filt_strobe  one-cycle pulse: filt_data carries a new result
//   res_data     FIFO head
//   res_valid    res_data holds a buffered result
//   res_ready    consumer accepts res_data
//   busy         high in every state except IDLE
//   done         one-cycle pulse when an acquisition completes without abort
//   timeout_err  sticky RUN-timeout flag, cleared by the next accepted arm
//   state_dbg    current FSM state, for observation only
//
// Handshake: a result transfers in every cycle where res_valid and res_ready
// are both high; res_data and res_valid do not depend on res_ready, and
// res_data holds steady while res_valid is high and res_ready is low.

module filter_acq_ctrl #(
  parameter int DW          = 28,
  parameter int NWIN        = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic          clock_in,
  input  logic          reset,
  input  logic          arm,
  input  logic          trig,
  input  logic          abort,
  input  logic [3:0]    win_count,
  output logic          filt_en,
  output logic          filt_clr,
  input  logic [DW-1:0] filt_data,
  input  logic          filt_strobe,
  output logic [DW-1:0] res_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic [2:0]    state_dbg
);

  localparam int AW = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int CW = $clog2(NWIN + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_RUN       = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wtarget_q, wcnt_q, fifo_cnt_q;
  logic [CW-1:0]   wclamp;
  logic [TW-1:0]   tcnt_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]   mem_q [NWIN];
  logic            timeout_q;

  logic            abort_eff, push, pop, last_strobe, tmo_hit, flush, drained;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (int'(p) == NWIN - 1) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wclamp = CW'(win_count);
    if (win_count == 4'd0)
      wclamp = CW'(1);
    else if (int'(win_count) > NWIN)
      wclamp = CW'(NWIN);
  end

  assign abort_eff   = abort && (state_q != S_IDLE);
  // Strobes only count while the filter is enabled.
  assign push        = (state_q == S_RUN) && filt_strobe && !abort;
  assign pop         = res_valid && res_ready;
  assign last_strobe = push && ((wcnt_q + CW'(1)) == wtarget_q);
  // The timeout counter holds the number of earlier strobe-free RUN cycles,
  // so this fires on the TIMEOUT_CYC-th consecutive silent cycle.
  assign tmo_hit     = (state_q == S_RUN) && !filt_strobe &&
                       (tcnt_q == TW'(TIMEOUT_CYC - 1));
  assign flush       = (state_q == S_CLEAR) || abort_eff;
  // Leave DRAIN in the cycle the last result is taken, not one later.
  assign drained     = (fifo_cnt_q == '0) || ((fifo_cnt_q == CW'(1)) && pop);

  always_comb begin
    state_d = state_q;
    if (abort_eff) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (arm) state_d = S_CLEAR;
        S_CLEAR:     state_d = S_WAIT_TRIG;
        S_WAIT_TRIG: if (trig) state_d = S_RUN;
        S_RUN:       if (last_strobe || tmo_hit) state_d = S_DRAIN;
        S_DRAIN:     if (drained) state_d = S_DONE;
        S_DONE:      state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wtarget_q  <= CW'(1);
      wcnt_q     <= '0;
      tcnt_q     <= '0;
      timeout_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < NWIN; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;

      if ((state_q == S_IDLE) && arm) begin
        wtarget_q <= wclamp;
        timeout_q <= 1'b0;
      end else if (tmo_hit && !abort) begin
        timeout_q <= 1'b1;
      end

      if (state_q == S_CLEAR) begin
        wcnt_q <= '0;
        tcnt_q <= '0;
      end else if (state_q == S_RUN) begin
        if (push) begin
          wcnt_q <= wcnt_q + CW'(1);
          tcnt_q <= '0;
        end else if (!tmo_hit) begin
          tcnt_q <= tcnt_q + TW'(1);
        end
      end

      if (flush) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fifo_cnt_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= filt_data;
          wr_ptr_q        <= ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  assign filt_en     = (state_q == S_RUN);
  assign filt_clr    = (state_q != S_RUN);
  assign busy        = (state_q != S_IDLE);
  // An abort in the DONE cycle suppresses the completion pulse.
  assign done        = (state_q == S_DONE) && !abort;
  assign res_valid   = (fifo_cnt_q != '0);
  assign res_data    = mem_q[rd_ptr_q];
  assign timeout_err = timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_filter_acq_ctrl.sv
module tb_filter_acq_ctrl;

  localparam int DW   = 28;
  localparam int NWIN = 8;
  localparam int TMO  = 16;

  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_WAIT  = 2;
  localparam int M_RUN   = 3;
  localparam int M_DRAIN = 4;
  localparam int M_DONE  = 5;

  // clock / reset / DUT signals
  logic          clock_in = 1'b0;
  logic          reset;
  logic          arm, trig, abort, filt_strobe, res_ready;
  logic [3:0]    win_count;
  logic [DW-1:0] filt_data;
  logic          filt_en, filt_clr, res_valid, busy, done, timeout_err;
  logic [DW-1:0] res_data;
  logic [2:0]    state_dbg;

  always #5 clock_in = ~clock_in;

  filter_acq_ctrl #(.DW(DW), .NWIN(NWIN), .TIMEOUT_CYC(TMO)) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .arm         (arm),
    .trig        (trig),
    .abort       (abort),
    .win_count   (win_count),
    .filt_en     (filt_en),
    .filt_clr    (filt_clr),
    .filt_data   (filt_data),
    .filt_strobe (filt_strobe),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // bookkeeping
  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 1;   // 0: never ready, 1: always ready, 2: random
  int n_pop, n_done;

  // reference model: acquisition phase, targets and result queue
  logic [DW-1:0] exp_q[$];
  int  m_mode = M_IDLE;
  int  m_target, m_got, m_quiet;
  logic m_terr;
  bit  m_known = 0;
  bit  m_zero_head = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int clamp_wc(input int wc);
    if (wc == 0) return 1;
    if (wc > NWIN) return NWIN;
    return wc;
  endfunction

  // Outputs predicted from the model with the current inputs applied.
  task automatic check_outputs();
    if (!m_known) return;
    chk("filt_en",     64'(filt_en),     64'(m_mode == M_RUN));
    chk("filt_clr",    64'(filt_clr),    64'(m_mode != M_RUN));
    chk("busy",        64'(busy),        64'(m_mode != M_IDLE));
    chk("done",        64'(done),        64'(m_mode == M_DONE && !abort));
    chk("res_valid",   64'(res_valid),   64'(exp_q.size() > 0));
    chk("timeout_err", 64'(timeout_err), 64'(m_terr));
    if (exp_q.size() > 0)
      chk("res_data", 64'(res_data), 64'(exp_q[0]));
    else if (m_zero_head)
      chk("res_data_rst", 64'(res_data), 64'd0);
    if (res_valid && res_ready) n_pop++;
    if (done) n_done++;
  endtask

  // Advance the model across one rising edge using the applied inputs.
  task automatic model_step();
    bit pop;
    if (!reset) begin
      m_known = 1; m_mode = M_IDLE; exp_q.delete(); m_terr = 0;
      m_zero_head = 1; m_got = 0; m_quiet = 0; m_target = 1;
      return;
    end
    if (!m_known) return;
    pop = (exp_q.size() > 0) && res_ready;
    if (abort && m_mode != M_IDLE) begin
      m_mode = M_IDLE;
      exp_q.delete();
      return;
    end
    if (pop) void'(exp_q.pop_front());
    case (m_mode)
      M_IDLE: if (arm) begin
        m_target = clamp_wc(int'(win_count));
        m_terr = 0;
        m_mode = M_CLEAR;
      end
      M_CLEAR: begin
        exp_q.delete(); m_got = 0; m_quiet = 0; m_mode = M_WAIT;
      end
      M_WAIT: if (trig) m_mode = M_RUN;
      M_RUN: begin
        if (filt_strobe) begin
          exp_q.push_back(filt_data);
          m_zero_head = 0;
          m_got++;
          m_quiet = 0;
          if (m_got == m_target) m_mode = M_DRAIN;
        end else begin
          m_quiet++;
          if (m_quiet == TMO) begin
            m_terr = 1;
            m_mode = M_DRAIN;
          end
        end
      end
      M_DRAIN: if (exp_q.size() == 0) m_mode = M_DONE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    case (ready_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = ($urandom_range(99) < 60);
    endcase
    @(negedge clock_in);
    check_outputs();
    model_step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic strobe(input logic [DW-1:0] d, input int gap);
    repeat (gap) tick();
    filt_strobe = 1'b1;
    filt_data = d;
    tick();
    filt_strobe = 1'b0;
    filt_data = DW'($urandom);
  endtask

  task automatic arm_trig(input int wc, input int trig_delay);
    win_count = 4'(wc);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    win_count = 4'($urandom);
    repeat (trig_delay - 1) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 400 && busy; k++) tick();
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic clear_counts();
    n_pop = 0;
    n_done = 0;
  endtask

  initial begin
    arm = 0; trig = 0; abort = 0; filt_strobe = 0; res_ready = 1;
    win_count = 0; filt_data = 0; reset = 0;
    repeat (3) tick();
    reset = 1;
    tick();
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_clr", 64'(filt_clr), 64'd1);

    // nominal: three windows, trigger five cycles after arm
    ready_mode = 1; clear_counts();
    arm_trig(3, 5);
    strobe(DW'(100), 2);
    strobe(DW'(200), 1);
    strobe(DW'(300), 3);
    wait_idle("nom_idle");
    chk("nom_pops", 64'(n_pop), 64'd3);
    chk("nom_done", 64'(n_done), 64'd1);
    chk("nom_terr", 64'(timeout_err), 64'd0);

    // backpressure: all eight results held, then released
    ready_mode = 0; clear_counts();
    arm_trig(8, 3);
    for (int i = 0; i < 8; i++) strobe(DW'($urandom), $urandom_range(2));
    repeat (3) tick();
    chk("bp_no_done", 64'(n_done), 64'd0);
    chk("bp_pops_held", 64'(n_pop), 64'd0);
    ready_mode = 1;
    wait_idle("bp_idle");
    chk("bp_pops", 64'(n_pop), 64'd8);
    chk("bp_done", 64'(n_done), 64'd1);

    // clamp low: win_count 0 collects one result
    ready_mode = 2; clear_counts();
    arm_trig(0, 2);
    strobe(DW'($urandom), 1);
    strobe(DW'($urandom), 1);
    wait_idle("clamp0_idle");
    chk("clamp0_pops", 64'(n_pop), 64'd1);

    // clamp high: win_count 12 collects eight; ninth back-to-back strobe dropped
    ready_mode = 1; clear_counts();
    arm_trig(12, 2);
    for (int i = 0; i < 9; i++) strobe(DW'(1000 + i), 0);
    wait_idle("clamp12_idle");
    chk("clamp12_pops", 64'(n_pop), 64'd8);

    // timeout: two strobes then silence
    clear_counts();
    arm_trig(4, 2);
    strobe(DW'($urandom), 1);
    strobe(DW'($urandom), 2);
    wait_idle("tmo_idle");
    chk("tmo_err", 64'(timeout_err), 64'd1);
    chk("tmo_pops", 64'(n_pop), 64'd2);
    chk("tmo_done", 64'(n_done), 64'd1);
    win_count = 4'd1; arm = 1; tick(); arm = 0;
    chk("tmo_cleared", 64'(timeout_err), 64'd0);
    abort = 1; tick(); abort = 0;

    // abort in RUN with two results buffered
    ready_mode = 0; clear_counts();
    arm_trig(5, 2);
    strobe(DW'($urandom), 0);
    strobe(DW'($urandom), 1);
    abort = 1; tick(); abort = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(res_valid), 64'd0);
    chk("abort_clr", 64'(filt_clr), 64'd1);
    repeat (3) tick();
    chk("abort_nodone", 64'(n_done), 64'd0);
    ready_mode = 1;

    // abort and trig together in WAIT_TRIG
    win_count = 4'd2; arm = 1; tick(); arm = 0; tick();
    trig = 1; abort = 1; tick(); trig = 0; abort = 0;
    chk("abtrig_busy", 64'(busy), 64'd0);
    chk("abtrig_en", 64'(filt_en), 64'd0);

    // reset in the middle of RUN with results buffered
    ready_mode = 0;
    arm_trig(4, 2);
    strobe(DW'($urandom), 0);
    strobe(DW'($urandom), 0);
    reset = 0; tick(); reset = 1;
    chk("rstrun_busy", 64'(busy), 64'd0);
    chk("rstrun_valid", 64'(res_valid), 64'd0);
    chk("rstrun_data", 64'(res_data), 64'd0);
    chk("rstrun_en", 64'(filt_en), 64'd0);
    ready_mode = 1;

    // arm and trig together in IDLE: trig must not start RUN
    win_count = 4'd3; arm = 1; trig = 1; tick(); arm = 0; trig = 0;
    repeat (3) begin
      chk("armtrig_en", 64'(filt_en), 64'd0);
      chk("armtrig_busy", 64'(busy), 64'd1);
      tick();
    end
    abort = 1; tick(); abort = 0;

    // randomized soak: busy strobes first, then sparse ones to reach timeouts
    ready_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      arm         = ($urandom_range(99) < 8);
      trig        = ($urandom_range(99) < 15);
      abort       = ($urandom_range(199) < 2);
      filt_strobe = ($urandom_range(99) < ((i < 2000) ? 35 : 3));
      filt_data   = DW'($urandom);
      win_count   = 4'($urandom);
      reset       = !($urandom_range(399) == 0);
      tick();
    end
    arm = 0; trig = 0; filt_strobe = 0; reset = 1; abort = 1;
    tick();
    abort = 0;
    ready_mode = 1;
    wait_idle("soak_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
